ring_token_arbiter: RTL and testbench
=====================================

Name: ring_token_arbiter

Overview:
- Per-core ring stage that sits directly downstream of the local ring clients (barrier unit, semaphore unit, messenger, etc.).
- Consumes their WantsToken/DriveRing/RingOut requests and grants the circulating token to one client at a time, round-robin.
- Strips slots that have completed a full lap, and registers the core's ring output toward the next core.
- Injects the single initial token after reset on the token-master core.

Parameters:
- NREQ, 4, number of local ring clients.
- MASTER_CORE, 1, whichCore value that injects the initial token.
- WDOG_CYCLES, 4096, token-loss timeout; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- whichCore  in  4  this core's ring ID.
- RingIn  in  32  incoming slot data; also broadcast unmodified to all clients.
- SlotTypeIn  in  4  incoming slot type.
- SourceIn  in  4  incoming slot source.
- wantsToken  in  NREQ  per-client token request.
- driveRing  in  NREQ  per-client "my slot is valid this cycle".
- clientRingOut  in  32*NREQ  per-client slot data (client i at bits [32i+31:32i]).
- clientSlotTypeOut  in  4*NREQ  per-client slot type.
- clientSourceOut  in  4*NREQ  per-client source.
- acquireToken  out  NREQ  one-hot grant, combinational, asserted in the token-arrival cycle.
- RingOut  out  32  registered slot data to next core.
- SlotTypeOut  out  4  registered slot type.
- SourceOut  out  4  registered slot source.
- tokenLost  out  1  sticky watchdog flag.

Behaviour:
- Slot codes (package): Null=0, Token=1; all other codes are messages.
- Reset:
  - RingOut=0, SlotTypeOut=Null, SourceOut=0, acquireToken=0, tokenLost=0, rrPtr=0.
  - state=inject if whichCore==MASTER_CORE, else idle.
- Strip rule:
  - Incoming slot is "own" if type is neither Null nor Token and SourceIn==whichCore.
  - An own slot is treated as Null for forwarding: replaced by Null, data 0, source 0. Clients still see it on the broadcast.
- States:
  - inject:
    - Forward incoming slots.
    - First cycle the incoming slot is Null or own: output Token (data 0, source whichCore), then go to idle.
  - idle:
    - Incoming Token with no wantsToken bit set: forward Token unchanged next cycle; stay idle.
    - Incoming Token with any wantsToken bit set: assert acquireToken[g] for winner g this cycle; register client g's slot as output; go to hold.
    - Other slots: forward (after strip rule).
  - hold:
    - Incoming slot is Null or own: output Token; go to idle.
    - Otherwise forward the incoming slot; stay in hold.
- Grant rules:
  - Latency: token in at cycle t, granted client's slot out at t+1; forwarded slots also appear at t+1.
  - At most one grant per token arrival.
  - Round-robin search starts at rrPtr. On grant, rrPtr <= (g+1) mod NREQ. rrPtr is unchanged when there is no grant.
  - driveRing[g] must be high in the grant cycle. If it is low, output Null instead of the client slot, and still go to hold.
- Boundary conditions:
  - Token arriving while in hold or inject is illegal. Forward it unchanged and go to idle; this prevents token duplication.
  - wantsToken dropping in the arrival cycle: only currently asserted bits compete.
  - driveRing while not granted: ignored.
  - Reset mid-hold: the held token is lost; the master re-injects it.

Optional Feature:
- Macro: RING_TOKEN_WATCHDOG_EN.
- With it:
  - A 16-bit counter clears on every incoming or outgoing Token and otherwise increments, saturating.
  - Reaching WDOG_CYCLES sets tokenLost; it clears only on reset.
- Without it: tokenLost is tied to 0 and no counter is built.

Decomposition:
- Shared ring package:
  - Slot-type codes: Null, Token, Barrier, etc.
  - Slot field widths: 32/4/4.
  - nCores.
- Sub-module rr_arbiter: NREQ request vector plus pointer in, one-hot grant plus any-grant out; purely combinational.
- FSM, strip rule, output register and watchdog stay in ring_token_arbiter.

Test Plan:
1. Reset with whichCore=1 and Null stream: SlotTypeOut=Null for 1 cycle, then Token with SourceOut=1 on the first Null input; then state is idle. With whichCore=2, no Token is ever emitted.
2. Token in, wantsToken=0010, client1 drives Barrier/src 3: acquireToken=0010 in the same cycle; next cycle SlotTypeOut=Barrier, SourceOut=3. Following Null input produces Token out.
3. wantsToken=1111 held over 4 token arrivals from rrPtr=0: grants 0001, 0010, 0100, 1000 in order, then 0001 on the 5th.
4. In hold, inputs Barrier(src 5), Barrier(src 6), then own slot (src=whichCore): first two forwarded unchanged; own slot replaced by Token; state idle.
5. Token in with no requests: Token out at t+1 with unchanged data/source; acquireToken stays 0.
6. With RING_TOKEN_WATCHDOG_EN and WDOG_CYCLES=8: no Token for 8 cycles sets tokenLost=1; it stays 1 after later Tokens until reset.

Source files
------------

// File: rtl/ring_token_arbiter_pkg.sv
// ring_token_arbiter_pkg
//   Shared ring definitions for the per-core ring stage and its clients:
//   slot field widths, slot-type codes, core count, arbiter FSM states and
//   the "own slot" helper used by the strip logic.
package ring_token_arbiter_pkg;

  localparam int SLOT_DATA_W = 32;
  localparam int SLOT_TYPE_W = 4;
  localparam int SLOT_SRC_W  = 4;
  localparam int nCores      = 16;

  // Slot-type codes; every code other than Null and Token is a message.
  typedef enum logic [SLOT_TYPE_W-1:0] {
    SLOT_NULL      = 4'd0,
    SLOT_TOKEN     = 4'd1,
    SLOT_BARRIER   = 4'd2,
    SLOT_SEMAPHORE = 4'd3,
    SLOT_MESSAGE   = 4'd4
  } slotType_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INJECT = 2'd1,
    ST_HOLD   = 2'd2
  } arbState_e;

  // A message slot that this core originated has made a full lap.
  function automatic logic isOwnSlot(input logic [SLOT_TYPE_W-1:0] slotType,
                                     input logic [SLOT_SRC_W-1:0]  source,
                                     input logic [SLOT_SRC_W-1:0]  core);
    return (slotType != SLOT_NULL) && (slotType != SLOT_TOKEN) && (source == core);
  endfunction

endpackage

// File: rtl/ring_token_arbiter_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin picker. The search begins at ptr and
//   wraps; the first requesting index wins.
//   Ports:
//     req      in  NREQ  request vector
//     ptr      in  PTRW  index with highest priority this cycle (< NREQ)
//     grant    out NREQ  one-hot winner (all zero when no request)
//     anyGrant out 1     some request was granted
module rr_arbiter
  import ring_token_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic            anyGrant
);

  // Walk the requesters starting at ptr and keep the first hit.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = {NREQ{1'b0}};
    anyGrant = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!anyGrant && req[idx]) begin
        grant[idx] = 1'b1;
        anyGrant   = 1'b1;
      end else begin
        anyGrant = anyGrant;
      end
    end
  end

endmodule

// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
//   Per-core ring stage downstream of the local ring clients. Grants the
//   circulating token round-robin, strips slots that have completed a lap,
//   registers the ring output toward the next core and injects the single
//   initial token on the master core.
//   Optional build macro: RING_TOKEN_WATCHDOG_EN (token-loss watchdog; when
//   undefined tokenLost is tied low and no counter exists).
//   Ports:
//     clock, reset                 clock, synchronous active-high reset
//     whichCore                    this core's ring ID
//     RingIn/SlotTypeIn/SourceIn   incoming slot (also seen by clients)
//     wantsToken, driveRing        per-client request / slot-valid
//     clientRingOut/SlotTypeOut/SourceOut  per-client slots, client i at lane i
//     acquireToken                 combinational one-hot grant
//     RingOut/SlotTypeOut/SourceOut registered slot to next core
//     tokenLost                    sticky watchdog flag
module ring_token_arbiter
  import ring_token_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int MASTER_CORE = 1,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [SLOT_SRC_W-1:0]       whichCore,
  input  logic [SLOT_DATA_W-1:0]      RingIn,
  input  logic [SLOT_TYPE_W-1:0]      SlotTypeIn,
  input  logic [SLOT_SRC_W-1:0]       SourceIn,
  input  logic [NREQ-1:0]             wantsToken,
  input  logic [NREQ-1:0]             driveRing,
  input  logic [SLOT_DATA_W*NREQ-1:0] clientRingOut,
  input  logic [SLOT_TYPE_W*NREQ-1:0] clientSlotTypeOut,
  input  logic [SLOT_SRC_W*NREQ-1:0]  clientSourceOut,
  output logic [NREQ-1:0]             acquireToken,
  output logic [SLOT_DATA_W-1:0]      RingOut,
  output logic [SLOT_TYPE_W-1:0]      SlotTypeOut,
  output logic [SLOT_SRC_W-1:0]       SourceOut,
  output logic                        tokenLost
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                   ownSlot_s;
  logic                   freeSlot_s;
  logic                   tokenIn_s;
  logic [SLOT_DATA_W-1:0] fwdData_s;
  logic [SLOT_TYPE_W-1:0] fwdType_s;
  logic [SLOT_SRC_W-1:0]  fwdSrc_s;

  arbState_e              state_r;
  arbState_e              nextState_s;
  logic [PTRW-1:0]        rrPtr_r;
  logic [PTRW-1:0]        nextPtr_s;
  logic [PTRW-1:0]        winIdx_s;
  logic [NREQ-1:0]        grant_s;
  logic                   anyGrant_s;
  logic [NREQ-1:0]        acquire_s;

  logic [SLOT_DATA_W-1:0] ringOut_r;
  logic [SLOT_TYPE_W-1:0] slotTypeOut_r;
  logic [SLOT_SRC_W-1:0]  sourceOut_r;
  logic [SLOT_DATA_W-1:0] nextData_s;
  logic [SLOT_TYPE_W-1:0] nextType_s;
  logic [SLOT_SRC_W-1:0]  nextSrc_s;

  // An own slot is forwarded as an empty slot; clients still saw it on RingIn.
  assign ownSlot_s  = isOwnSlot(SlotTypeIn, SourceIn, whichCore);
  assign freeSlot_s = (SlotTypeIn == SLOT_NULL) || ownSlot_s;
  assign tokenIn_s  = (SlotTypeIn == SLOT_TOKEN);
  assign fwdType_s  = ownSlot_s ? SLOT_NULL : SlotTypeIn;
  assign fwdData_s  = ownSlot_s ? 32'd0 : RingIn;
  assign fwdSrc_s   = ownSlot_s ? 4'd0 : SourceIn;

  rr_arbiter #(
    .NREQ(NREQ),
    .PTRW(PTRW)
  ) uRrArbiter (
    .req     (wantsToken),
    .ptr     (rrPtr_r),
    .grant   (grant_s),
    .anyGrant(anyGrant_s)
  );

  // Encode the one-hot grant into a client index.
  always_comb begin
    winIdx_s = {PTRW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        winIdx_s = PTRW'(i);
      end else begin
        winIdx_s = winIdx_s;
      end
    end
  end

  // Next-state, grant and next ring-slot selection.
  always_comb begin
    nextState_s = state_r;
    nextPtr_s   = rrPtr_r;
    nextType_s  = fwdType_s;
    nextData_s  = fwdData_s;
    nextSrc_s   = fwdSrc_s;
    acquire_s   = {NREQ{1'b0}};
    case (state_r)
      ST_INJECT: begin
        if (tokenIn_s) begin
          // A token already exists: pass it on rather than create a second.
          nextState_s = ST_IDLE;
        end else if (freeSlot_s) begin
          nextType_s  = SLOT_TOKEN;
          nextData_s  = 32'd0;
          nextSrc_s   = whichCore;
          nextState_s = ST_IDLE;
        end else begin
          nextState_s = ST_INJECT;
        end
      end
      ST_IDLE: begin
        if (tokenIn_s && anyGrant_s) begin
          acquire_s   = grant_s;
          nextPtr_s   = (winIdx_s == PTRW'(NREQ - 1)) ? {PTRW{1'b0}} : winIdx_s + PTRW'(1);
          nextState_s = ST_HOLD;
          if (driveRing[winIdx_s]) begin
            nextData_s = clientRingOut[SLOT_DATA_W*int'(winIdx_s) +: SLOT_DATA_W];
            nextType_s = clientSlotTypeOut[SLOT_TYPE_W*int'(winIdx_s) +: SLOT_TYPE_W];
            nextSrc_s  = clientSourceOut[SLOT_SRC_W*int'(winIdx_s) +: SLOT_SRC_W];
          end else begin
            // Granted client had nothing valid: the token slot goes out empty.
            nextData_s = 32'd0;
            nextType_s = SLOT_NULL;
            nextSrc_s  = 4'd0;
          end
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (tokenIn_s) begin
          nextState_s = ST_IDLE;
        end else if (freeSlot_s) begin
          // First free slot after our message: release the token.
          nextType_s  = SLOT_TOKEN;
          nextData_s  = 32'd0;
          nextSrc_s   = whichCore;
          nextState_s = ST_IDLE;
        end else begin
          nextState_s = ST_HOLD;
        end
      end
      default: begin
        nextState_s = ST_IDLE;
      end
    endcase
  end

  assign acquireToken = reset ? {NREQ{1'b0}} : acquire_s;

  // State, round-robin pointer and registered ring output.
  always_ff @(posedge clock) begin
    if (reset) begin
      ringOut_r     <= 32'd0;
      slotTypeOut_r <= SLOT_NULL;
      sourceOut_r   <= 4'd0;
      rrPtr_r       <= {PTRW{1'b0}};
      state_r       <= (whichCore == 4'(MASTER_CORE)) ? ST_INJECT : ST_IDLE;
    end else begin
      ringOut_r     <= nextData_s;
      slotTypeOut_r <= nextType_s;
      sourceOut_r   <= nextSrc_s;
      rrPtr_r       <= nextPtr_s;
      state_r       <= nextState_s;
    end
  end

  assign RingOut     = ringOut_r;
  assign SlotTypeOut = slotTypeOut_r;
  assign SourceOut   = sourceOut_r;

`ifdef RING_TOKEN_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

  logic [15:0] wdogCnt_r;
  logic        tokenLost_r;

  // Count cycles without a token passing in either direction; flag is sticky.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdogCnt_r   <= 16'd0;
      tokenLost_r <= 1'b0;
    end else begin
      if ((SlotTypeIn == SLOT_TOKEN) || (slotTypeOut_r == SLOT_TOKEN)) begin
        wdogCnt_r <= 16'd0;
      end else if (wdogCnt_r != 16'hFFFF) begin
        wdogCnt_r <= wdogCnt_r + 16'd1;
      end else begin
        wdogCnt_r <= wdogCnt_r;
      end
      if (wdogCnt_r >= WDOG_LIMIT) begin
        tokenLost_r <= 1'b1;
      end else begin
        tokenLost_r <= tokenLost_r;
      end
    end
  end

  assign tokenLost = tokenLost_r;
`else
  assign tokenLost = 1'b0;
`endif

endmodule

// File: tb/tb_ring_token_arbiter.sv
// tb_ring_token_arbiter
//   Table-driven bench with an expected-output queue. Inputs are driven on
//   the falling edge, the combinational grant is sampled 1ns later, and the
//   registered slot is checked at the following falling edge.
module tb_ring_token_arbiter;
  import ring_token_arbiter_pkg::*;

  localparam int NREQ = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    whichCore;
  logic [31:0]   RingIn;
  logic [3:0]    SlotTypeIn;
  logic [3:0]    SourceIn;
  logic [3:0]    wantsToken;
  logic [3:0]    driveRing;
  logic [127:0]  clientRingOut;
  logic [15:0]   clientSlotTypeOut;
  logic [15:0]   clientSourceOut;
  logic [3:0]    acquireToken;
  logic [31:0]   RingOut;
  logic [3:0]    SlotTypeOut;
  logic [3:0]    SourceOut;
  logic          tokenLost;

  always #5 clock = ~clock;

  ring_token_arbiter #(
    .NREQ(NREQ),
    .MASTER_CORE(1),
    .WDOG_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .wantsToken(wantsToken), .driveRing(driveRing),
    .clientRingOut(clientRingOut), .clientSlotTypeOut(clientSlotTypeOut),
    .clientSourceOut(clientSourceOut), .acquireToken(acquireToken),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .tokenLost(tokenLost)
  );

  typedef struct {
    logic [3:0]  typ;
    logic [3:0]  src;
    logic [31:0] data;
    logic [3:0]  want;
    logic [3:0]  drive;
    logic [3:0]  expAcq;
    logic [3:0]  expType;
    logic [3:0]  expSrc;
    logic [31:0] expData;
  } vec_t;

  typedef struct {
    logic [3:0]  typ;
    logic [3:0]  src;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [3:0]  N  = 4'd0;
  localparam logic [3:0]  T  = 4'd1;
  localparam logic [3:0]  B  = 4'd2;
  localparam logic [31:0] C0 = 32'hC0DE_0000;
  localparam logic [31:0] C1 = 32'hC0DE_0001;
  localparam logic [31:0] C2 = 32'hC0DE_0002;
  localparam logic [31:0] C3 = 32'hC0DE_0003;

  function automatic vec_t mkv(input logic [3:0] typ, input logic [3:0] src,
                               input logic [31:0] data, input logic [3:0] want,
                               input logic [3:0] drive, input logic [3:0] expAcq,
                               input logic [3:0] expType, input logic [3:0] expSrc,
                               input logic [31:0] expData);
    vec_t v;
    v.typ = typ; v.src = src; v.data = data; v.want = want; v.drive = drive;
    v.expAcq = expAcq; v.expType = expType; v.expSrc = expSrc; v.expData = expData;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyVec(input vec_t v, input string tag);
    exp_t e;
    RingIn     = v.data;
    SlotTypeIn = v.typ;
    SourceIn   = v.src;
    wantsToken = v.want;
    driveRing  = v.drive;
    #1;
    chk({tag, " acquireToken"}, 32'(acquireToken), 32'(v.expAcq));
    e.typ = v.expType; e.src = v.expSrc; e.data = v.expData; e.tag = tag;
    expQ.push_back(e);
    @(negedge clock);
    e = expQ.pop_front();
    chk({e.tag, " SlotTypeOut"}, 32'(SlotTypeOut), 32'(e.typ));
    chk({e.tag, " SourceOut"},   32'(SourceOut),   32'(e.src));
    chk({e.tag, " RingOut"},     RingOut,          e.data);
  endtask

  task automatic doReset(input logic [3:0] core, input string tag);
    reset      = 1'b1;
    whichCore  = core;
    RingIn     = 32'd0;
    SlotTypeIn = N;
    SourceIn   = 4'd0;
    wantsToken = 4'd0;
    driveRing  = 4'd0;
    @(negedge clock);
    @(negedge clock);
    chk({tag, " rst RingOut"},      RingOut,              32'd0);
    chk({tag, " rst SlotTypeOut"},  32'(SlotTypeOut),     32'd0);
    chk({tag, " rst SourceOut"},    32'(SourceOut),       32'd0);
    chk({tag, " rst acquireToken"}, 32'(acquireToken),    32'd0);
    chk({tag, " rst tokenLost"},    32'(tokenLost),       32'd0);
    reset = 1'b0;
  endtask

  task automatic nullFor(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyVec(mkv(N, 4'd0, 32'd0, 4'd0, 4'd0, 4'd0, N, 4'd0, 32'd0), tag);
    end
  endtask

  initial begin
    // Client i always offers a Barrier from source i+2.
    for (int i = 0; i < NREQ; i++) begin
      clientRingOut[32*i +: 32]    = 32'hC0DE_0000 | 32'(i);
      clientSlotTypeOut[4*i +: 4]  = B;
      clientSourceOut[4*i +: 4]    = 4'(i + 2);
    end

    // Master core (whichCore = 1): injection, round robin, strip, corners.
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'h0, 4'h0, 4'h0, T, 4'd1, 32'd0)); // inject
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'h0, 4'h0, 4'h0, N, 4'd0, 32'd0)); // idle now
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'hF, 4'hF, 4'h1, B, 4'd2, C0));
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'hF, 4'hF, 4'h0, T, 4'd1, 32'd0));
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'hF, 4'hF, 4'h2, B, 4'd3, C1));
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'hF, 4'hF, 4'h0, T, 4'd1, 32'd0));
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'hF, 4'hF, 4'h4, B, 4'd4, C2));
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'hF, 4'hF, 4'h0, T, 4'd1, 32'd0));
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'hF, 4'hF, 4'h8, B, 4'd5, C3));
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'hF, 4'hF, 4'h0, T, 4'd1, 32'd0));
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'hF, 4'hF, 4'h1, B, 4'd2, C0)); // wraps
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'h0, 4'h0, 4'h0, T, 4'd1, 32'd0));
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'h2, 4'h2, 4'h2, B, 4'd3, C1)); // single req
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'h0, 4'h0, 4'h0, T, 4'd1, 32'd0));
    tbl.push_back(mkv(T, 4'd7, 32'h55, 4'h0, 4'h0, 4'h0, T, 4'd7, 32'h55)); // no req
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'h4, 4'h4, 4'h4, B, 4'd4, C2));
    tbl.push_back(mkv(B, 4'd5, 32'hA5, 4'h0, 4'h0, 4'h0, B, 4'd5, 32'hA5)); // hold fwd
    tbl.push_back(mkv(B, 4'd6, 32'h5A, 4'h0, 4'h0, 4'h0, B, 4'd6, 32'h5A));
    tbl.push_back(mkv(B, 4'd1, 32'h77, 4'h0, 4'h0, 4'h0, T, 4'd1, 32'd0));  // own -> Token
    tbl.push_back(mkv(B, 4'd1, 32'h99, 4'h0, 4'h0, 4'h0, N, 4'd0, 32'd0));  // own stripped
    tbl.push_back(mkv(B, 4'd9, 32'h33, 4'h0, 4'hF, 4'h0, B, 4'd9, 32'h33)); // stray drive
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'h8, 4'h0, 4'h8, N, 4'd0, 32'd0));  // no driveRing
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'hF, 4'hF, 4'h0, T, 4'd1, 32'd0));  // token in hold
    tbl.push_back(mkv(T, 4'd1, 32'd0,  4'hF, 4'hF, 4'h1, B, 4'd2, C0));     // idle again
    tbl.push_back(mkv(N, 4'd0, 32'd0,  4'h0, 4'h0, 4'h0, T, 4'd1, 32'd0));

    doReset(4'd1, "master");
    for (int i = 0; i < tbl.size(); i++) begin
      applyVec(tbl[i], $sformatf("row%0d", i));
    end

    // Non-master core never creates a token, only forwards one.
    doReset(4'd2, "slave");
    nullFor(6, "slaveNull");
    applyVec(mkv(T, 4'd3, 32'h12, 4'h0, 4'h0, 4'h0, T, 4'd3, 32'h12), "slaveTok");
`ifndef RING_TOKEN_WATCHDOG_EN
    chk("tokenLost tied low", 32'(tokenLost), 32'd0);
`endif

    // Reset while holding: the master re-injects, waiting for a free slot.
    doReset(4'd1, "midhold");
    applyVec(mkv(N, 4'd0, 32'd0, 4'h0, 4'h0, 4'h0, T, 4'd1, 32'd0), "mhInject");
    applyVec(mkv(T, 4'd1, 32'd0, 4'h1, 4'h1, 4'h1, B, 4'd2, C0),    "mhGrant");
    doReset(4'd1, "rehold");
    applyVec(mkv(B, 4'd5, 32'h1, 4'h0, 4'h0, 4'h0, B, 4'd5, 32'h1),  "reFwd");
    applyVec(mkv(N, 4'd0, 32'd0, 4'h0, 4'h0, 4'h0, T, 4'd1, 32'd0), "reInject");
    applyVec(mkv(N, 4'd0, 32'd0, 4'h0, 4'h0, 4'h0, N, 4'd0, 32'd0), "reIdle");

`ifdef RING_TOKEN_WATCHDOG_EN
    doReset(4'd2, "wdog");
    nullFor(3, "wdogEarly");
    chk("wdog early tokenLost", 32'(tokenLost), 32'd0);
    nullFor(12, "wdogLate");
    chk("wdog tokenLost set", 32'(tokenLost), 32'd1);
    applyVec(mkv(T, 4'd3, 32'd0, 4'h0, 4'h0, 4'h0, T, 4'd3, 32'd0), "wdogTok");
    nullFor(1, "wdogAfter");
    chk("wdog tokenLost sticky", 32'(tokenLost), 32'd1);
    doReset(4'd2, "wdogClear");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
